// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state encoding and register-address constants for the hazard unit
package hazard_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;
  typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX stall interface between pipeline (slave) and hazard unit (master)
// Statistics counter signals exist only when HAZARD_STATS_EN is defined.
interface hazard_ctrl_if import hazard_pkg::*; #(parameter int CNT_W = 16);
  logic                  MemRead_ex;
  logic [REG_ADDR_W-1:0] rdAddr_ex;
  logic [REG_ADDR_W-1:0] rs1Addr_id;
  logic [REG_ADDR_W-1:0] rs2Addr_id;
  logic                  rs1Used_id;
  logic                  rs2Used_id;
  logic                  BranchTaken_ex;
  logic                  MemAccess_mem;
  logic                  MemReady_mem;
  logic                  PC_IFWrite;
  logic                  IF_ID_Write;
  logic                  IF_ID_Flush;
  logic                  Stall;
  logic                  Freeze;
  logic                  MemTimeout;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0]      LoadUseCnt;
  logic [CNT_W-1:0]      FlushCnt;
  logic [CNT_W-1:0]      FreezeCnt;
`endif
  modport master (
    input  MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
           BranchTaken_ex, MemAccess_mem, MemReady_mem,
    output PC_IFWrite, IF_ID_Write, IF_ID_Flush, Stall, Freeze, MemTimeout
`ifdef HAZARD_STATS_EN
    , output LoadUseCnt, FlushCnt, FreezeCnt
`endif
  );
  modport slave (
    output MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
           BranchTaken_ex, MemAccess_mem, MemReady_mem,
    input  PC_IFWrite, IF_ID_Write, IF_ID_Flush, Stall, Freeze, MemTimeout
`ifdef HAZARD_STATS_EN
    , input LoadUseCnt, FlushCnt, FreezeCnt
`endif
  );
endinterface

// File: rtl/hazard_memwait_fsm.sv
// hazard_memwait_fsm: tracks data-memory wait cycles, raises freeze_req and a sticky timeout error
module hazard_memwait_fsm import hazard_pkg::*; #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_access,
  input  logic mem_ready,
  output logic freeze_req,
  output logic mem_timeout
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          mem_wait;
  assign mem_wait = mem_access & ~mem_ready;
  // Gated by rst_n so a pending wait cannot freeze the pipeline while reset is held
  assign freeze_req = rst_n & ((state == ERR) | mem_wait);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: if (mem_wait) begin
          state    <= MEMWAIT;
          wait_cnt <= CW'(1);
        end
        MEMWAIT: if (!mem_wait) begin
          state    <= RUN;
          wait_cnt <= '0;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          state       <= ERR;
          mem_timeout <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + CW'(1);
        end
        default: state <= ERR;
      endcase
    end
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch / memory-wait hazard control for the 5-stage pipeline
// Define HAZARD_STATS_EN to add saturating LoadUseCnt/FlushCnt/FreezeCnt counters.
module hazard_ctrl import hazard_pkg::*; #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.master hz
);
  logic freeze_req, load_use, p1, p2, p3;
  hazard_memwait_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_access (hz.MemAccess_mem),
    .mem_ready  (hz.MemReady_mem),
    .freeze_req (freeze_req),
    .mem_timeout(hz.MemTimeout)
  );
  assign load_use = hz.MemRead_ex & (hz.rdAddr_ex != X0) &
                    ((hz.rs1Used_id & (hz.rs1Addr_id == hz.rdAddr_ex)) |
                     (hz.rs2Used_id & (hz.rs2Addr_id == hz.rdAddr_ex)));
  assign p1 = freeze_req;
  assign p2 = rst_n & ~p1 & hz.BranchTaken_ex;
  assign p3 = rst_n & ~p1 & ~hz.BranchTaken_ex & load_use;
  assign hz.Freeze      = p1;
  assign hz.IF_ID_Flush = p2;
  assign hz.Stall       = p2 | p3;
  assign hz.PC_IFWrite  = ~(p1 | p3);
  assign hz.IF_ID_Write = ~(p1 | p3);
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] lu_cnt, fl_cnt, fz_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt <= '0;
      fl_cnt <= '0;
      fz_cnt <= '0;
    end else begin
      if (p3 && !(&lu_cnt)) lu_cnt <= lu_cnt + CNT_W'(1);
      if (p2 && !(&fl_cnt)) fl_cnt <= fl_cnt + CNT_W'(1);
      if (p1 && !(&fz_cnt)) fz_cnt <= fz_cnt + CNT_W'(1);
    end
  end
  assign hz.LoadUseCnt = lu_cnt;
  assign hz.FlushCnt   = fl_cnt;
  assign hz.FreezeCnt  = fz_cnt;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (TIMEOUT=8, CNT_W=2)
module tb_hazard_ctrl;
  localparam logic [5:0] OK = 6'b110000;
  localparam logic [5:0] LU = 6'b000100;
  localparam logic [5:0] BR = 6'b111100;
  localparam logic [5:0] FZ = 6'b000010;
  localparam logic [5:0] TO = 6'b000011;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [5:0] sb[$];
  always #5 clk = ~clk;
  hazard_ctrl_if #(.CNT_W(2)) hz();
  hazard_ctrl #(.TIMEOUT(8), .CNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [5:0] outs();
    return {hz.PC_IFWrite, hz.IF_ID_Write, hz.IF_ID_Flush, hz.Stall, hz.Freeze, hz.MemTimeout};
  endfunction
  task automatic drive(input logic mr, input logic [4:0] rd, rs1, rs2,
                       input logic u1, u2, br, acc, rdy);
    hz.MemRead_ex = mr; hz.rdAddr_ex = rd; hz.rs1Addr_id = rs1; hz.rs2Addr_id = rs2;
    hz.rs1Used_id = u1; hz.rs2Used_id = u2; hz.BranchTaken_ex = br;
    hz.MemAccess_mem = acc; hz.MemReady_mem = rdy;
  endtask
  task automatic expect_now(input string tag, input logic [5:0] exp);
    sb.push_back(exp);
    #1;
    check(tag, outs(), sb.pop_front());
  endtask
  task automatic step(input string tag, input logic mr, input logic [4:0] rd, rs1, rs2,
                      input logic u1, u2, br, acc, rdy, input logic [5:0] exp);
    @(negedge clk);
    drive(mr, rd, rs1, rs2, u1, u2, br, acc, rdy);
    expect_now(tag, exp);
  endtask
  task automatic idle(input string tag, input logic [5:0] exp);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp);
  endtask
  task automatic wt(input string tag, input logic br, input logic [5:0] exp);
    step(tag, 0, 0, 0, 0, 0, 0, br, 1, 0, exp);
  endtask
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    expect_now(tag, OK);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask
  initial begin
    drive(1, 5, 5, 0, 1, 0, 1, 1, 0);
    repeat (2) @(negedge clk);
    expect_now("reset_outputs", OK);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle("idle", OK);
    step("lu_rs1", 1, 5, 5, 0, 1, 0, 0, 0, 0, LU);
    idle("lu_bubble_release", OK);
    step("lu_rd_x0", 1, 0, 0, 0, 1, 0, 0, 0, 0, OK);
    step("lu_rs1_unused", 1, 5, 5, 0, 0, 0, 0, 0, 0, OK);
    step("lu_rs2", 1, 7, 1, 7, 1, 1, 0, 0, 0, LU);
    step("lu_rs2_unused", 1, 7, 1, 7, 1, 0, 0, 0, 0, OK);
    step("branch_over_lu", 1, 5, 5, 0, 1, 0, 1, 0, 0, BR);
    for (int i = 0; i < 3; i++) wt($sformatf("memwait_br_%0d", i), 1, FZ);
    step("memwait_release_br", 0, 0, 0, 0, 0, 0, 1, 1, 1, BR);
    idle("after_release", OK);
    wt("drop_w0", 0, FZ);
    wt("drop_w1", 0, FZ);
    idle("access_drop", OK);
    idle("after_drop", OK);
    wt("rstmid_w0", 0, FZ);
    wt("rstmid_w1", 0, FZ);
    async_reset("async_rst_memwait");
    idle("after_rst_mid", OK);
    for (int i = 0; i < 7; i++) wt($sformatf("fresh_wait_%0d", i), 0, FZ);
    step("release_at_limit", 0, 0, 0, 0, 0, 0, 0, 1, 1, OK);
    idle("no_timeout", OK);
    for (int i = 0; i < 8; i++) wt($sformatf("to_wait_%0d", i), 0, FZ);
    wt("timeout_rise", 0, TO);
    step("err_ready_back", 0, 0, 0, 0, 0, 0, 1, 1, 1, TO);
    idle("err_absorbing", TO);
    async_reset("async_rst_err");
    idle("after_err_rst", OK);
    step("st_lu0", 1, 3, 3, 0, 1, 0, 0, 0, 0, LU);
    idle("st_i0", OK);
    step("st_lu1", 1, 4, 0, 4, 0, 1, 0, 0, 0, LU);
    step("st_br", 0, 0, 0, 0, 0, 0, 1, 0, 0, BR);
    for (int i = 0; i < 5; i++) wt($sformatf("st_fz_%0d", i), 0, FZ);
    idle("st_release", OK);
`ifdef HAZARD_STATS_EN
    idle("st_settle", OK);
    check("LoadUseCnt", hz.LoadUseCnt, 2);
    check("FlushCnt", hz.FlushCnt, 1);
    check("FreezeCnt_sat", hz.FreezeCnt, 3);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
